// File: rtl/quad_keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low column strobing, two-flop row sync,
// frame-level debounce FSM producing press/release strobes and a key code.
module quad_keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 50_000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held,
    output logic       multi_key
);

    localparam int PW = 20;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB_LAST   = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHECK,
        HELD,
        RELEASE_CHECK
    } state_t;

    logic [3:0]    rows_meta_q, rows_sync_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    cols_q, cols_d;
    logic [15:0]   map_q, map_d;
    logic          eval_q, eval_d;
    logic          tick;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          held_q, held_d;
    logic          valid_q, valid_d;
    logic          rel_q, rel_d;
    logic          multi_q, multi_d;

    logic [4:0]    ones;
    logic [3:0]    single_code;
    logic          is_single, is_multi, cand_set;

    // Scan timing: column changes and sampling both happen on the terminal count.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
        cols_d    = tick ? ~(4'b0001 << col_idx_d) : cols_q;
        eval_d    = tick && (col_idx_q == 2'd3);
        map_d     = map_q;
        if (tick) begin
            for (int r = 0; r < 4; r++) begin
                map_d[{r[1:0], col_idx_q}] = ~rows_sync_q[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta_q <= 4'b1111;
            rows_sync_q <= 4'b1111;
            presc_q     <= '0;
            col_idx_q   <= 2'd0;
            cols_q      <= 4'b1110;
            map_q       <= '0;
            eval_q      <= 1'b0;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
            presc_q     <= presc_d;
            col_idx_q   <= col_idx_d;
            cols_q      <= cols_d;
            map_q       <= map_d;
            eval_q      <= eval_d;
        end
    end

    // Frame classification; map_q is stable during the evaluation cycle.
    always_comb begin
        ones        = '0;
        single_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (map_q[i]) begin
                ones        = ones + 5'd1;
                single_code = 4'(i);
            end
        end
        is_single = (ones == 5'd1);
        is_multi  = (ones >= 5'd2);
        cand_set  = map_q[cand_q];
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        held_d  = held_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        multi_d = multi_q;
        if (eval_q) begin
            multi_d = is_multi;
            unique case (state_q)
                IDLE: begin
                    if (is_single) begin
                        cand_d  = single_code;
                        cnt_d   = 4'd1;
                        state_d = PRESS_CHECK;
                    end
                end
                PRESS_CHECK: begin
                    if (is_single && single_code == cand_q) begin
                        if (cnt_q + 4'd1 == DEB_LAST) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (is_single) begin
                        cand_d = single_code;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    // Extra keys alongside the held one are ignored: no rollover press.
                    if (cand_set) begin
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE_CHECK;
                    end
                end
                RELEASE_CHECK: begin
                    if (!cand_set) begin
                        if (cnt_q + 4'd1 == DEB_LAST) begin
                            rel_d   = 1'b1;
                            held_d  = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = HELD;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= 4'd0;
            code_q  <= 4'd0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            rel_q   <= rel_d;
            multi_q <= multi_d;
        end
    end

    assign cols        = cols_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;
    assign key_held    = held_q;
    assign multi_key   = multi_q;

endmodule

// File: doc/quad_keypad_scanner.md
Name: quad_keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and reading four pulled-up row lines.
- Debounces the scanned result and reports single key presses as a 4-bit code with one-cycle press and release strobes.
- It is the input-side counterpart of the board's multiplexed 4-digit SSD driver: same active-low one-hot strobing scheme, same 50 MHz clock, same prescaler style.
- Sits between the keypad header pins and the user logic, e.g. stopwatch start/stop/clear control.

Parameters:
- SCAN_DIV, 50_000, clock cycles each column stays active (1 kHz column rate at 50 MHz); legal range 4..2^20-1.
- DEBOUNCE_FRAMES, 4, consecutive full scan frames a key state must be stable to be accepted; legal range 2..15.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous, active-high reset.
- rows  input  4  keypad row lines, active-low (external pull-ups), asynchronous to clk.
- cols  output  4  column drive, active-low one-hot.
- key_code  output  4  last accepted key, code = row*4 + col.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_release  output  1  one-cycle pulse when the held key's release is accepted.
- key_held  output  1  level; accepted key currently held.
- multi_key  output  1  level; two or more keys seen in the last completed frame.

Behaviour:
- Reset is synchronous, active-high.
- Reset values: cols=4'b1110, key_code=0, key_valid=0, key_release=0, key_held=0, multi_key=0.
- Reset also clears: synchronizer to 4'b1111, column index 0, prescaler 0, frame map 0, FSM IDLE, stable count 0.
- Reset mid-operation aborts any pending press/release with no strobe.
- Row synchronization: rows pass through two flops before use; nothing downstream sees the raw rows.
- Prescaler: counts 0..SCAN_DIV-1.
- At terminal count:
  - the inverted synchronized rows are written into the 4 frame-map bits of the current column;
  - the column index advances 0->1->2->3->0;
  - cols = ~(1 << index), registered.
- Sampling at the end of the dwell gives SCAN_DIV-3 cycles of settling.
- Frame complete: the cycle in which column 3's sample is written.
- Frame evaluation happens one cycle after frame complete, using the full 16-bit map:
  - none = 0 bits set;
  - single = exactly 1 bit set, giving its code;
  - multi = 2 or more bits set.
- multi_key is updated at every evaluation.
- Debounce FSM, stepped only at evaluation:
  - IDLE:
    - single -> candidate=code, count=1, go to PRESS_CHECK;
    - none/multi -> stay.
  - PRESS_CHECK:
    - same single -> count+1;
    - when count reaches DEBOUNCE_FRAMES: key_code<=candidate, key_valid=1 for that cycle, key_held<=1, go to HELD;
    - different single -> candidate=new code, count=1, stay;
    - none/multi -> IDLE, count 0.
  - HELD:
    - candidate bit set (alone or with others) -> stay, count 0;
    - candidate bit clear -> count=1, go to RELEASE_CHECK.
  - RELEASE_CHECK:
    - candidate bit clear -> count+1;
    - when count reaches DEBOUNCE_FRAMES: key_release=1 for that cycle, key_held<=0, go to IDLE;
    - candidate bit set -> back to HELD, count 0 (bounce absorbed).
- key_valid and key_release are never asserted in the same cycle. Each strobe is exactly one clk cycle.
- key_code holds its value until the next accepted press. It is unchanged on release.
- A second key pressed while HELD never produces key_valid.
- After release is accepted, a still-held key is accepted through IDLE->PRESS_CHECK as normal.
- Latency from a clean closure to key_valid:
  - at most (DEBOUNCE_FRAMES+1) frames + 3 cycles;
  - at least (DEBOUNCE_FRAMES-1) frames + 1 cycle;
  - where frame = 4*SCAN_DIV cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 cycles; the bench keypad model drives rows[r] low while cols[c]=0 and key r,c is closed):
- Scan and reset:
  - release rst -> cols=1110 for 4 cycles, then 1101, 1011, 0111, and back to 1110 at cycle 16;
  - all outputs 0 throughout with no keys.
- Clean press of key row2/col1:
  - close it for 10 frames -> exactly one key_valid pulse within 66 cycles, key_code=9, key_held=1, no key_release;
  - then open it -> one key_release pulse within 66 cycles, key_held=0, key_code still 9.
- Bounce:
  - key 5 pattern: closed 2 frames, open 1, closed 2, open 1 -> no key_valid, key_held=0;
  - then closed 3 frames -> single key_valid with key_code=5.
- Multi key:
  - keys 0 and 15 closed together -> multi_key=1, no key_valid;
  - release key 0 -> multi_key=0, key_valid with code 15 after 3 frames.
- Rollover while held:
  - hold key 3 until accepted, then add key 12 -> multi_key=1, no new key_valid, key_held stays 1;
  - release key 3 -> key_release after 3 frames;
  - key 12 then accepted with key_valid, code 12.
- Reset mid-operation:
  - assert rst for 1 cycle during PRESS_CHECK -> no strobes, cols=1110 the next cycle;
  - assert rst during HELD -> key_held=0 and key_code=0 the next cycle, and no key_release pulse.
